lpddr2_bridge: RTL and testbench

LPDDR2_BRIDGE -- requirements
Module: lpddr2_bridge

---
 rtl/lpddr2_bridge.sv | 109 ++++++++++
 tb/tb_lpddr2_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_bridge.sv
// Single-beat CPU-to-Avalon bridge for an LPDDR2 controller: edge-triggered
// read/write requests, one command in flight, and a timeout that latches into ERR.
module lpddr2_bridge #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_W         = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lpddr2_address,
  input  logic [31:0]       lpddr2_write_data,
  input  logic              lpddr2_rreq,
  input  logic              lpddr2_wreq,
  output logic [31:0]       lpddr2_read_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              avl_ready,
  output logic [ADDR_W-1:0] avl_address,
  output logic [31:0]       avl_writedata,
  output logic              avl_read,
  output logic              avl_write,
  output logic [3:0]        avl_be,
  output logic [2:0]        avl_burstcount,
  input  logic              avl_waitrequest,
  input  logic [31:0]       avl_readdata,
  input  logic              avl_readdatavalid
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {INIT, IDLE, WR_CMD, RD_CMD, RD_WAIT, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic          rreq_q, wreq_q;
  logic [CW-1:0] cnt;
  logic          rd_rise, wr_rise, timeout;

  assign rd_rise = lpddr2_rreq & ~rreq_q;
  assign wr_rise = lpddr2_wreq & ~wreq_q;
  // cnt holds cycles already spent in the state; this is the last allowed one
  assign timeout = (cnt >= TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (avl_ready) state_nxt = IDLE;
      IDLE: begin
        if (!avl_ready)   state_nxt = INIT;
        else if (wr_rise) state_nxt = WR_CMD;
        else if (rd_rise) state_nxt = RD_CMD;
      end
      WR_CMD: begin
        if (!avl_waitrequest) state_nxt = DONE;
        else if (timeout)     state_nxt = ERR;
      end
      RD_CMD: begin
        if (!avl_waitrequest) state_nxt = RD_WAIT;
        else if (timeout)     state_nxt = ERR;
      end
      RD_WAIT: begin
        if (avl_readdatavalid) state_nxt = DONE;
        else if (timeout)      state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= INIT;
      rreq_q           <= 1'b0;
      wreq_q           <= 1'b0;
      cnt              <= '0;
      avl_address      <= '0;
      avl_writedata    <= '0;
      lpddr2_read_data <= '0;
    end else begin
      state  <= state_nxt;
      // Edge history tracks every cycle, so a level held through a
      // transaction cannot look like a fresh edge back in IDLE.
      rreq_q <= lpddr2_rreq;
      wreq_q <= lpddr2_wreq;
      if (state_nxt != state)
        cnt <= '0;
      else if (cnt != {CW{1'b1}})
        cnt <= cnt + CW'(1);
      if (state == IDLE && state_nxt == WR_CMD) begin
        avl_address   <= lpddr2_address;
        avl_writedata <= lpddr2_write_data;
      end
      if (state == IDLE && state_nxt == RD_CMD)
        avl_address <= lpddr2_address;
      if (state == RD_WAIT && avl_readdatavalid)
        lpddr2_read_data <= avl_readdata;
    end
  end

  assign avl_write      = (state == WR_CMD);
  assign avl_read       = (state == RD_CMD);
  assign done           = (state == DONE);
  assign error          = (state == ERR);
  assign busy           = !(state == IDLE || state == DONE);
  assign avl_be         = 4'hF;
  assign avl_burstcount = 3'd1;

endmodule

// File: tb/tb_lpddr2_bridge.sv
// Directed bench for lpddr2_bridge: write, stalled read, collision, level hold,
// mid-read reset and timeout, with hand-computed expectations.
module tb_lpddr2_bridge;

  logic        clk, rst;
  logic [26:0] lpddr2_address;
  logic [31:0] lpddr2_write_data, lpddr2_read_data;
  logic        lpddr2_rreq, lpddr2_wreq, busy, done, error;
  logic        avl_ready, avl_read, avl_write, avl_waitrequest, avl_readdatavalid;
  logic [26:0] avl_address;
  logic [31:0] avl_writedata, avl_readdata;
  logic [3:0]  avl_be;
  logic [2:0]  avl_burstcount;

  int total = 0, bad = 0;
  int n_done = 0, n_rd = 0, n_wr = 0;
  int d0, r0, w0;

  lpddr2_bridge #(.TIMEOUT_CYCLES(8), .ADDR_W(27)) dut (
    .clk(clk), .rst(rst),
    .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
    .lpddr2_rreq(lpddr2_rreq), .lpddr2_wreq(lpddr2_wreq),
    .lpddr2_read_data(lpddr2_read_data), .busy(busy), .done(done), .error(error),
    .avl_ready(avl_ready), .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_read(avl_read), .avl_write(avl_write), .avl_be(avl_be),
    .avl_burstcount(avl_burstcount), .avl_waitrequest(avl_waitrequest),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done)      n_done++;
    if (avl_read)  n_rd++;
    if (avl_write) n_wr++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    d0 = n_done; r0 = n_rd; w0 = n_wr;
  endtask

  initial begin
    rst = 1'b0; avl_ready = 1'b0; lpddr2_address = '0; lpddr2_write_data = '0;
    lpddr2_rreq = 1'b0; lpddr2_wreq = 1'b0; avl_waitrequest = 1'b0;
    avl_readdata = '0; avl_readdatavalid = 1'b0;
    #12;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rdata", lpddr2_read_data, 0);
    check("rst_cmd", {avl_read, avl_write}, 0);
    check("rst_addr", avl_address, 0);
    check("rst_wdata", avl_writedata, 0);
    check("const_be", avl_be, 4'hF);
    check("const_burst", avl_burstcount, 3'd1);
    rst = 1'b1;
    tick(3);
    check("init_hold_busy", busy, 1);
    avl_ready = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // best-case write
    snap();
    lpddr2_address = 27'h0000010; lpddr2_write_data = 32'hDEADBEEF; lpddr2_wreq = 1'b1;
    tick();
    lpddr2_address = 27'h7FFFFFF; lpddr2_write_data = 32'h0;
    check("wr_cmd", {avl_write, avl_read}, 2'b10);
    check("wr_addr_latched", avl_address, 27'h0000010);
    check("wr_data_latched", avl_writedata, 32'hDEADBEEF);
    check("wr_busy", busy, 1);
    check("wr_no_done_c1", done, 0);
    tick();
    check("wr_done_c2", done, 1);
    check("wr_done_busy", busy, 0);
    check("wr_cmd_off", avl_write, 0);
    tick();
    check("wr_done_single", done, 0);
    lpddr2_wreq = 1'b0;
    tick();
    check("wr_cycles", n_wr - w0, 1);
    check("wr_done_cnt", n_done - d0, 1);

    // read with 3 stall cycles and data 4 cycles after command accept
    snap();
    lpddr2_address = 27'h0000020; avl_waitrequest = 1'b1; lpddr2_rreq = 1'b1;
    tick();
    check("rd_cmd", {avl_read, avl_write}, 2'b10);
    check("rd_addr", avl_address, 27'h0000020);
    tick(3);
    avl_waitrequest = 1'b0;
    check("rd_cmd_c4", avl_read, 1);
    tick();
    check("rd_wait_cmd_off", avl_read, 0);
    check("rd_wait_busy", busy, 1);
    tick(3);
    avl_readdatavalid = 1'b1; avl_readdata = 32'h12345678;
    tick();
    avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
    check("rd_done", done, 1);
    check("rd_data", lpddr2_read_data, 32'h12345678);
    tick();
    lpddr2_rreq = 1'b0;
    tick();
    check("rd_cycles", n_rd - r0, 4);
    check("rd_done_cnt", n_done - d0, 1);

    // simultaneous edges: write wins, read dropped
    snap();
    lpddr2_address = 27'h0000030; lpddr2_write_data = 32'hCAFEF00D;
    lpddr2_rreq = 1'b1; lpddr2_wreq = 1'b1;
    tick();
    check("coll_cmd", {avl_write, avl_read}, 2'b10);
    check("coll_wdata", avl_writedata, 32'hCAFEF00D);
    tick(4);
    lpddr2_rreq = 1'b0; lpddr2_wreq = 1'b0;
    tick();
    check("coll_rd_cycles", n_rd - r0, 0);
    check("coll_wr_cycles", n_wr - w0, 1);
    check("coll_done_cnt", n_done - d0, 1);

    // rreq held across two completions, then stray readdatavalid in IDLE
    snap();
    lpddr2_address = 27'h0000040; lpddr2_rreq = 1'b1;
    tick(2);
    avl_readdatavalid = 1'b1; avl_readdata = 32'hA5A5A5A5;
    tick();
    avl_readdatavalid = 1'b0;
    check("lvl_rd_done_c3", done, 1);
    check("lvl_rd_data", lpddr2_read_data, 32'hA5A5A5A5);
    tick(2);
    lpddr2_wreq = 1'b1;
    tick(4);
    lpddr2_wreq = 1'b0;
    tick(2);
    avl_readdatavalid = 1'b1; avl_readdata = 32'hFFFF0000;
    tick();
    avl_readdatavalid = 1'b0;
    tick();
    check("lvl_rd_cycles", n_rd - r0, 1);
    check("lvl_done_cnt", n_done - d0, 2);
    check("stray_rdv_ignored", lpddr2_read_data, 32'hA5A5A5A5);
    lpddr2_rreq = 1'b0;
    tick();

    // reset during RD_WAIT
    snap();
    lpddr2_address = 27'h0000050; lpddr2_rreq = 1'b1;
    tick(2);
    check("pre_rst_rd_wait", {busy, avl_read}, 2'b10);
    #2 rst = 1'b0; lpddr2_rreq = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1);
    check("mid_rst_rdata", lpddr2_read_data, 0);
    check("mid_rst_addr", avl_address, 0);
    check("mid_rst_done", done, 0);
    tick();
    rst = 1'b1;
    tick();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h55AA55AA;
    tick();
    avl_readdatavalid = 1'b0;
    tick(2);
    check("post_rst_rdata", lpddr2_read_data, 0);
    check("post_rst_done_cnt", n_done - d0, 0);
    check("post_rst_idle", busy, 0);

    // timeout with waitrequest stuck
    snap();
    avl_waitrequest = 1'b1; lpddr2_address = 27'h0000060; lpddr2_wreq = 1'b1;
    tick(8);
    check("to_c8_still_cmd", avl_write, 1);
    check("to_c8_no_err", error, 0);
    tick();
    check("to_err", error, 1);
    check("to_busy", busy, 1);
    check("to_cmd_off", {avl_write, avl_read}, 0);
    lpddr2_wreq = 1'b0;
    tick();
    lpddr2_rreq = 1'b1; avl_waitrequest = 1'b0;
    tick(3);
    check("to_ignore_req", {avl_read, avl_write, error}, 3'b001);
    check("to_no_done", n_done - d0, 0);
    check("to_wr_cycles", n_wr - w0, 8);
    rst = 1'b0;
    #1;
    check("to_rst_err_clear", error, 0);
    check("to_rst_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
